uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Merges two byte streams (debug and IEC) onto a single uart_tx. Each
//   channel has its own DEPTH-entry FIFO. An idle-state round-robin arbiter
//   picks the next channel. When the channel changes, and TAG_EN is set, a
//   one-byte channel tag is sent ahead of the data byte.
//
// Ports
//   clk                   rising-edge clock for all logic
//   rstn                  asynchronous active-low reset
//   dbg_byte, dbg_valid   debug channel push (one-cycle strobe)
//   iec_byte, iec_valid   IEC channel push (one-cycle strobe)
//   tx_byte, tx_valid     byte and one-cycle start strobe to uart_tx
//   tx_done               one-cycle completion pulse from uart_tx
//   dbg_full, iec_full    per-channel FIFO full flags
//   dbg_ovf, iec_ovf      sticky overflow flags (a push was dropped)
//   ovf_clr               clears both overflow flags
//   busy                  high when the FSM is not idle or any FIFO holds data
module uart_tx_arbiter #(
  parameter int          DEPTH   = 4,
  parameter bit          TAG_EN  = 1'b1,
  parameter logic [7:0]  TAG_DBG = 8'hF0,
  parameter logic [7:0]  TAG_IEC = 8'hF1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] dbg_byte,
  input  logic       dbg_valid,
  input  logic [7:0] iec_byte,
  input  logic       iec_valid,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  input  logic       tx_done,
  output logic       dbg_full,
  output logic       iec_full,
  output logic       dbg_ovf,
  output logic       iec_ovf,
  input  logic       ovf_clr,
  output logic       busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = 1;

  // Channel index 0 = debug, 1 = IEC.
  localparam logic CH_DBG = 1'b0;
  localparam logic CH_IEC = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TAG       = 3'd1,
    TAG_WAIT  = 3'd2,
    DATA      = 3'd3,
    DATA_WAIT = 3'd4
  } state_t;

  logic [1:0] push_valid;
  logic [7:0] push_byte [2];
  logic [1:0] full;
  logic [1:0] empty;
  logic [1:0] ovf;
  logic [1:0] pop;
  logic [7:0] head [2];

  assign push_valid   = {iec_valid, dbg_valid};
  assign push_byte[0] = dbg_byte;
  assign push_byte[1] = iec_byte;

  // Per-channel FIFO. Pointers carry one extra bit so that equal low bits
  // with differing top bits means full, and fully equal pointers mean empty.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic [7:0]  mem [DEPTH];
      logic [AW:0] wr_ptr_reg;
      logic [AW:0] rd_ptr_reg;
      logic        ovf_reg;
      logic        accept;

      assign empty[gi] = (wr_ptr_reg == rd_ptr_reg);
      assign full[gi]  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                         (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
      // A pop in the same cycle does not make room: the full flag is the
      // registered one, so a push on a full FIFO is always dropped.
      assign accept    = push_valid[gi] && !full[gi];
      assign head[gi]  = mem[rd_ptr_reg[AW-1:0]];
      assign ovf[gi]   = ovf_reg;

      always_ff @(posedge clk) begin
        if (accept) begin
          mem[wr_ptr_reg[AW-1:0]] <= push_byte[gi];
        end
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          ovf_reg    <= 1'b0;
        end else begin
          if (accept) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
          end
          if (pop[gi]) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
          end
          // A drop in the same cycle as a clear wins, so no event is lost.
          ovf_reg <= (ovf_reg && !ovf_clr) || (push_valid[gi] && full[gi]);
        end
      end
    end
  endgenerate

  assign dbg_full = full[0];
  assign iec_full = full[1];
  assign dbg_ovf  = ovf[0];
  assign iec_ovf  = ovf[1];

  state_t     state_reg, state_next;
  logic       sel_reg, sel_next;
  logic       last_ch_reg, last_ch_next;
  logic       sent_reg, sent_next;
  logic [7:0] tx_byte_reg, tx_byte_next;
  logic       pick_ch;

  // Round-robin: with both channels pending, take the one not served last.
  always_comb begin
    pick_ch = CH_DBG;
    if (!empty[0] && !empty[1]) begin
      pick_ch = ~last_ch_reg;
    end else if (empty[0]) begin
      pick_ch = CH_IEC;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      sel_reg     <= CH_DBG;
      last_ch_reg <= CH_IEC;
      sent_reg    <= 1'b0;
      tx_byte_reg <= 8'h00;
    end else begin
      state_reg   <= state_next;
      sel_reg     <= sel_next;
      last_ch_reg <= last_ch_next;
      sent_reg    <= sent_next;
      tx_byte_reg <= tx_byte_next;
    end
  end

  // tx_byte_reg is loaded on the edge that enters TAG or DATA, so the byte
  // is already in place during the strobe cycle and is held until the next
  // load, which cannot happen before tx_done.
  always_comb begin
    state_next   = state_reg;
    sel_next     = sel_reg;
    last_ch_next = last_ch_reg;
    sent_next    = sent_reg;
    tx_byte_next = tx_byte_reg;
    pop          = 2'b00;
    tx_valid     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty[0] || !empty[1]) begin
          sel_next = pick_ch;
          if (TAG_EN && ((pick_ch != last_ch_reg) || !sent_reg)) begin
            state_next   = TAG;
            tx_byte_next = (pick_ch == CH_IEC) ? TAG_IEC : TAG_DBG;
          end else begin
            state_next   = DATA;
            tx_byte_next = head[pick_ch];
          end
        end
      end
      TAG: begin
        tx_valid   = 1'b1;
        state_next = TAG_WAIT;
      end
      TAG_WAIT: begin
        // The channel is locked in sel_reg, so the data byte that follows
        // a tag always belongs to the tagged channel.
        if (tx_done) begin
          state_next   = DATA;
          tx_byte_next = head[sel_reg];
        end
      end
      DATA: begin
        tx_valid      = 1'b1;
        pop[sel_reg]  = 1'b1;
        last_ch_next  = sel_reg;
        sent_next     = 1'b1;
        state_next    = DATA_WAIT;
      end
      DATA_WAIT: begin
        if (tx_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign tx_byte = tx_byte_reg;
  assign busy    = (state_reg != IDLE) || !empty[0] || !empty[1];

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter. Two instances share all stimulus: u_dut0 with
// channel tags enabled, u_dut1 with tags disabled. A queue-level model
// predicts every strobed byte, flag and busy level. An automatic uart_tx
// responder, limited by a credit count, returns tx_done pulses. All model
// updates and checks run in one process, once per cycle on the falling edge.
module tb_uart_tx_arbiter;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] dbg_byte, iec_byte;
  logic       dbg_valid, iec_valid, ovf_clr, spur_done;

  logic [7:0] tx_byte_o  [2];
  logic       tx_valid_o [2];
  logic       dbg_full_o [2];
  logic       iec_full_o [2];
  logic       dbg_ovf_o  [2];
  logic       iec_ovf_o  [2];
  logic       busy_o     [2];
  logic       resp_done  [2];
  logic       dut_done   [2];

  assign dut_done[0] = resp_done[0] | spur_done;
  assign dut_done[1] = resp_done[1] | spur_done;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.DEPTH(DEPTH), .TAG_EN(1'b1)) u_dut0 (
    .clk(clk), .rstn(rstn),
    .dbg_byte(dbg_byte), .dbg_valid(dbg_valid),
    .iec_byte(iec_byte), .iec_valid(iec_valid),
    .tx_byte(tx_byte_o[0]), .tx_valid(tx_valid_o[0]), .tx_done(dut_done[0]),
    .dbg_full(dbg_full_o[0]), .iec_full(iec_full_o[0]),
    .dbg_ovf(dbg_ovf_o[0]), .iec_ovf(iec_ovf_o[0]),
    .ovf_clr(ovf_clr), .busy(busy_o[0])
  );

  uart_tx_arbiter #(.DEPTH(DEPTH), .TAG_EN(1'b0)) u_dut1 (
    .clk(clk), .rstn(rstn),
    .dbg_byte(dbg_byte), .dbg_valid(dbg_valid),
    .iec_byte(iec_byte), .iec_valid(iec_valid),
    .tx_byte(tx_byte_o[1]), .tx_valid(tx_valid_o[1]), .tx_done(dut_done[1]),
    .dbg_full(dbg_full_o[1]), .iec_full(iec_full_o[1]),
    .dbg_ovf(dbg_ovf_o[1]), .iec_ovf(iec_ovf_o[1]),
    .ovf_clr(ovf_clr), .busy(busy_o[1])
  );

  // Model state, indexed [instance][channel]; channel 0 = debug, 1 = IEC.
  logic [7:0] mq [2][2][16];
  int         mh [2][2];
  int         mn [2][2];
  bit         movf [2][2];
  int         mlast [2];
  bit         msent [2], mpend [2], mout [2], mstrobed [2];
  int         mpch [2];
  logic [7:0] mout_byte [2];
  logic [7:0] log_q [2][256];
  int         log_n [2], base [2];
  int         rcnt [2], cr_used [2], cr_given [2];
  bit         rowed [2];
  int         total = 0, bad = 0;

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s inst%0d actual=%h required=%h t=%0t", name, inst, act, expv, $time);
    end
  endtask

  task automatic mpop(input int i, input int ch, output logic [7:0] b);
    b = mq[i][ch][mh[i][ch]];
    mh[i][ch] = (mh[i][ch] + 1) % 16;
    mn[i][ch]--;
  endtask

  task automatic mpush(input int i, input int ch, input logic [7:0] b);
    mq[i][ch][(mh[i][ch] + mn[i][ch]) % 16] = b;
    mn[i][ch]++;
  endtask

  task automatic check_inst(input int i);
    logic [7:0] expb;
    int         ch;
    bit         strobe, fp0, fp1, ok;
    if (!rstn) begin
      chk("rst_tx_valid", i, tx_valid_o[i], 0);
      chk("rst_tx_byte", i, tx_byte_o[i], 0);
      chk("rst_dbg_full", i, dbg_full_o[i], 0);
      chk("rst_iec_full", i, iec_full_o[i], 0);
      chk("rst_dbg_ovf", i, dbg_ovf_o[i], 0);
      chk("rst_iec_ovf", i, iec_ovf_o[i], 0);
      chk("rst_busy", i, busy_o[i], 0);
      for (int c = 0; c < 2; c++) begin
        mn[i][c] = 0; mh[i][c] = 0; movf[i][c] = 0;
      end
      mlast[i] = 1; msent[i] = 0; mpend[i] = 0; mout[i] = 0; mstrobed[i] = 0;
      rcnt[i] = 0; rowed[i] = 0; resp_done[i] = 1'b0;
      return;
    end
    chk("dbg_full", i, dbg_full_o[i], mn[i][0] == DEPTH);
    chk("iec_full", i, iec_full_o[i], mn[i][1] == DEPTH);
    chk("dbg_ovf", i, dbg_ovf_o[i], movf[i][0]);
    chk("iec_ovf", i, iec_ovf_o[i], movf[i][1]);
    chk("busy", i, busy_o[i], (mn[i][0] != 0) || (mn[i][1] != 0) || mout[i] || mpend[i]);
    if (mout[i]) begin
      chk("no_strobe_outstanding", i, tx_valid_o[i], 0);
      chk("tx_byte_hold", i, tx_byte_o[i], mout_byte[i]);
    end else if (!tx_valid_o[i] && !mstrobed[i]) begin
      chk("tx_byte_reset_value", i, tx_byte_o[i], 0);
    end
    strobe = tx_valid_o[i] && !mout[i];

    // uart_tx responder: tx_done two cycles after the strobe, once credit allows.
    resp_done[i] = 1'b0;
    if (strobe) begin
      rcnt[i] = 2;
    end else if (rcnt[i] > 0) begin
      rcnt[i]--;
      if (rcnt[i] == 0) rowed[i] = 1;
    end
    if (rowed[i] && (cr_used[i] < cr_given[i])) begin
      resp_done[i] = 1'b1;
      rowed[i] = 0;
      cr_used[i]++;
    end

    fp0 = (mn[i][0] == DEPTH);
    fp1 = (mn[i][1] == DEPTH);
    if ((resp_done[i] | spur_done) && mout[i]) mout[i] = 0;

    if (strobe) begin
      ok = 1;
      expb = 8'h00;
      if (mpend[i]) begin
        mpop(i, mpch[i], expb);
        mlast[i] = mpch[i]; msent[i] = 1; mpend[i] = 0;
      end else begin
        if (mn[i][0] != 0 && mn[i][1] != 0) ch = (mlast[i] == 0) ? 1 : 0;
        else if (mn[i][0] != 0) ch = 0;
        else if (mn[i][1] != 0) ch = 1;
        else ch = -1;
        if (ch < 0) begin
          ok = 0;
          chk("strobe_with_nothing_queued", i, tx_valid_o[i], 0);
        end else if (i == 0 && (ch != mlast[i] || !msent[i])) begin
          expb = (ch == 1) ? 8'hF1 : 8'hF0;
          mpend[i] = 1; mpch[i] = ch;
        end else begin
          mpop(i, ch, expb);
          mlast[i] = ch; msent[i] = 1;
        end
      end
      if (ok) begin
        $display("inst%0d tx byte=%h expected=%h t=%0t", i, tx_byte_o[i], expb, $time);
        chk("strobe_byte", i, tx_byte_o[i], expb);
        log_q[i][log_n[i]] = tx_byte_o[i];
        log_n[i]++;
        mout[i] = 1; mout_byte[i] = expb; mstrobed[i] = 1;
      end
    end

    if (dbg_valid && !fp0) mpush(i, 0, dbg_byte);
    if (iec_valid && !fp1) mpush(i, 1, iec_byte);
    movf[i][0] = (movf[i][0] && !ovf_clr) || (dbg_valid && fp0);
    movf[i][1] = (movf[i][1] && !ovf_clr) || (iec_valid && fp1);
  endtask

  // Advance one clock: model/check on the falling edge, return 1 after rise.
  task automatic step();
    @(negedge clk);
    check_inst(0);
    check_inst(1);
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_idle();
    bit r = 1;
    for (int i = 0; i < 2; i++)
      if (mn[i][0] != 0 || mn[i][1] != 0 || mout[i] || mpend[i]) r = 0;
    return r;
  endfunction

  task automatic wait_drain(input string name);
    for (int k = 0; k < 300 && !model_idle(); k++) step();
    chk(name, 0, model_idle(), 1);
    step();
    step();
  endtask

  task automatic push(input bit dv, input logic [7:0] db, input bit iv, input logic [7:0] ib);
    dbg_valid = dv; dbg_byte = db; iec_valid = iv; iec_byte = ib;
    step();
    dbg_valid = 0; iec_valid = 0;
  endtask

  task automatic do_reset();
    rstn = 0;
    step();
    step();
    rstn = 1;
    step();
  endtask

  task automatic mark();
    base[0] = log_n[0];
    base[1] = log_n[1];
  endtask

  // Literal expected sequence, bytes packed MSB-first into v.
  task automatic check_log(input int i, input int n, input logic [63:0] v, input string name);
    int got;
    got = log_n[i] - base[i];
    chk({name, "_count"}, i, got, n);
    for (int k = 0; k < n; k++)
      if (k < got) chk(name, i, log_q[i][base[i] + k], v[8*(n-1-k) +: 8]);
  endtask

  initial begin
    rstn = 0; dbg_byte = 0; iec_byte = 0; dbg_valid = 0; iec_valid = 0;
    ovf_clr = 0; spur_done = 0;
    resp_done[0] = 0; resp_done[1] = 0;
    log_n[0] = 0; log_n[1] = 0;
    cr_used[0] = 0; cr_used[1] = 0;
    cr_given[0] = 32'h4000_0000; cr_given[1] = 32'h4000_0000;
    @(posedge clk);
    #1;
    do_reset();

    // Single debug byte is tagged; a second byte on the same channel is not.
    mark();
    push(1, 8'h41, 0, 8'h00);
    wait_drain("drain_41");
    check_log(0, 2, 64'hF041, "seq_41");
    check_log(1, 1, 64'h41, "seq_41");
    mark();
    push(1, 8'h42, 0, 8'h00);
    wait_drain("drain_42");
    check_log(0, 1, 64'h42, "seq_42");
    check_log(1, 1, 64'h42, "seq_42");

    // Simultaneous pushes on both channels alternate, debug first.
    do_reset();
    mark();
    push(1, 8'h01, 1, 8'hA1);
    push(1, 8'h02, 1, 8'hA2);
    wait_drain("drain_rr");
    check_log(0, 8, 64'hF001F1A1F002F1A2, "seq_rr");
    check_log(1, 4, 64'h01A102A2, "seq_rr");

    // Five debug pushes with tx_done withheld: fill, drop, overflow, clear.
    do_reset();
    cr_given[0] = cr_used[0];
    cr_given[1] = cr_used[1];
    mark();
    for (int k = 1; k <= 5; k++) push(1, 8'(k), 0, 8'h00);
    chk("lit_dbg_full", 0, dbg_full_o[0], 1);
    chk("lit_dbg_ovf", 0, dbg_ovf_o[0], 1);
    chk("lit_dbg_full", 1, dbg_full_o[1], 1);
    chk("lit_dbg_ovf", 1, dbg_ovf_o[1], 0);
    ovf_clr = 1;
    step();
    ovf_clr = 0;
    chk("lit_ovf_cleared", 0, dbg_ovf_o[0], 0);
    cr_given[0] = 32'h4000_0000;
    cr_given[1] = 32'h4000_0000;
    wait_drain("drain_ovf");
    check_log(0, 5, 64'hF001020304, "seq_ovf");
    check_log(1, 5, 64'h0102030405, "seq_ovf");

    // IEC-only stream: tagged once with tags on, plain with tags off.
    do_reset();
    mark();
    push(0, 8'h00, 1, 8'h10);
    push(0, 8'h00, 1, 8'h11);
    push(0, 8'h00, 1, 8'h12);
    wait_drain("drain_iec");
    check_log(0, 4, 64'hF1101112, "seq_iec");
    check_log(1, 3, 64'h101112, "seq_iec");

    // Reset while waiting for tx_done on a data byte with two bytes queued.
    do_reset();
    cr_given[0] = cr_used[0] + 1;
    cr_given[1] = cr_used[1];
    push(1, 8'h01, 0, 8'h00);
    push(1, 8'h02, 0, 8'h00);
    push(1, 8'h03, 0, 8'h00);
    for (int k = 0; k < 12; k++) step();
    chk("lit_busy_before_reset", 0, busy_o[0], 1);
    chk("lit_full_before_reset", 1, dbg_full_o[1], 0);
    rstn = 0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("lit_async_tx_valid", i, tx_valid_o[i], 0);
      chk("lit_async_tx_byte", i, tx_byte_o[i], 0);
      chk("lit_async_busy", i, busy_o[i], 0);
    end
    step();
    rstn = 1;
    cr_given[0] = 32'h4000_0000;
    cr_given[1] = 32'h4000_0000;
    step();
    mark();
    push(1, 8'h55, 0, 8'h00);
    wait_drain("drain_55");
    check_log(0, 2, 64'hF055, "seq_55");
    check_log(1, 1, 64'h55, "seq_55");

    // Stray tx_done while idle must not start anything.
    spur_done = 1;
    step();
    spur_done = 0;
    for (int k = 0; k < 5; k++) step();
    for (int i = 0; i < 2; i++) begin
      chk("lit_idle_busy", i, busy_o[i], 0);
      chk("lit_idle_tx_valid", i, tx_valid_o[i], 0);
    end
    mark();
    push(1, 8'h77, 0, 8'h00);
    wait_drain("drain_77");
    check_log(0, 1, 64'h77, "seq_77");
    check_log(1, 1, 64'h77, "seq_77");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
